dcache_ctrl_two_ways: RTL and testbench
=======================================

Name: dcache_ctrl_two_ways

Overview:
Controller for the data-side cache between the EX/MEM stage and word-addressed backing data memory. It is a 2-way set-associative, write-back, write-allocate cache with 1-bit LRU per set. On a hit it serves the request combinationally. On a miss it raises the pipeline stall, writes back a dirty victim if needed, then refills the line through a req/ready handshake. It also keeps request and miss counters for performance readout.

Parameters:
SETS_LOG, 4, log2 of set count (16 sets)
LINE_LOG, 2, log2 of words per line (4 words)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
addr  in  ADDR_W  CPU byte address; word-aligned, addr[1:0] ignored
wr_data  in  32  CPU store data
MemRead  in  1  load request
MemWrite  in  1  store request; takes priority if MemRead is also high
rd_data  out  32  load data, valid when MemRead=1 and miss=0
miss  out  1  stall request to the hazard unit (combinational)
mem_req  out  1  backing-memory beat request (registered)
mem_we  out  1  1 = write-back beat, 0 = refill beat
mem_addr  out  ADDR_W  beat word address (byte address, bits[1:0]=0)
mem_wdata  out  32  write-back data
mem_rdata  in  32  refill data, valid with mem_ready
mem_ready  in  1  beat completes on a cycle where mem_req & mem_ready
count_wr_rd_req  out  32  accepted CPU accesses
count_cache_miss  out  32  misses

Behaviour:
- Address split: offset = addr[LINE_LOG+1:2]; index = next SETS_LOG bits; tag = remaining upper bits.
- Storage per way/set: valid, dirty, tag, and a data line. Per set: lru bit, which names the way to evict next.
- Reset (rstn=0 at a clk edge), from any state including mid-transfer:
  - state goes to IDLE; all valid, dirty and lru bits clear; both counters clear.
  - mem_req=0, mem_we=0, beat counter=0.
  - Data arrays are not cleared.
- req = MemRead | MemWrite.
- States: IDLE, WB, REFILL.
- IDLE, hit (valid & tag match in either way):
  - miss=0; rd_data = word from the matching way, same cycle.
  - Store: at the clk edge, write the word and set dirty.
  - lru[index] <= the other way.
  - count_wr_rd_req increments.
- IDLE, req and no hit:
  - miss=1 in the same cycle; count_cache_miss increments.
  - Victim: way0 if invalid; else way1 if invalid; else the way named by lru.
  - Next state is WB if the victim is valid and dirty, else REFILL; the beat counter starts at 0.
- IDLE, no req: miss=0, no state change, counters hold.
- WB:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, beat, 2'b00}; mem_wdata = victim word[beat].
  - On each completed beat, beat increments. After the last beat (beat = 2^LINE_LOG-1), go to REFILL with beat=0.
- REFILL:
  - mem_req=1, mem_we=0; mem_addr = {req tag, index, beat, 2'b00}.
  - On each completed beat, write mem_rdata into the victim word[beat].
  - After the last beat: set victim valid=1, dirty=0, tag = req tag; go to IDLE.
- Re-presentation after a miss: the pipeline holds addr, MemRead and MemWrite during miss. On return to IDLE the request hits, miss drops, and the access is counted once.
- miss stays 1 in every cycle spent in WB or REFILL.
- Beats: mem_req falls the cycle after the final beat completes. With mem_ready tied high, each beat takes 1 cycle, and mem_ready low stretches the beat indefinitely.
- Inputs and handshake signals:
  - mem_ready is ignored when mem_req=0.
  - Input changes during WB/REFILL are undefined and are not checked.
- Counters wrap modulo 2^32.
- Outputs in IDLE with no req: rd_data = 0, mem_addr = 0, mem_wdata = 0.

Test Plan:
- Cold read: after reset, MemRead of 0x100, mem_ready=1, memory word at A = A+0x1000 -> miss=1 for 5 cycles (1 IDLE + 4 REFILL); beats fetch 0x100..0x10C; then rd_data=0x1100 with miss=0; counters req=1, miss=1.
- Hit: read 0x104 next -> miss=0 in the same cycle, rd_data=0x1104, no mem_req; req=2.
- Dirty eviction: write 0x208 <= 0xDEADBEEF (miss, refills way1); read 0x100 (hit, lru=way1); read 0x300:
  - write-back beats to 0x200..0x20C, with 0xDEADBEEF at 0x208;
  - then refill of 0x300..0x30C;
  - miss=1 for 9 cycles; rd_data=0x1300.
- Stalled handshake: cold read 0x400 with mem_ready=0 for 3 cycles before each beat -> mem_req and mem_addr stay stable; miss persists for 17 cycles; data is correct.
- Reset mid-refill: assert rstn=0 during beat 2 of a refill -> next cycle mem_req=0, counters=0; a re-read of the same address misses again (the line is invalid).
- Simultaneous MemRead & MemWrite on a hit line -> the store is performed, dirty is set, and req increments by 1.

Source files
------------

// File: rtl/dcache_ctrl_two_ways.sv
// Two-way set-associative write-back data cache controller with 1-bit LRU per set.
// Hits are served combinationally; misses stall, write back a dirty victim, then refill.
module dcache_ctrl_two_ways #(
  parameter int SETS_LOG = 4,
  parameter int LINE_LOG = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       rd_data,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       count_wr_rd_req,
  output logic [31:0]       count_cache_miss
);
  localparam int SETS   = 1 << SETS_LOG;
  localparam int WORDS  = 1 << LINE_LOG;
  localparam int TAG_LO = LINE_LOG + SETS_LOG + 2;
  localparam int TAG_W  = ADDR_W - TAG_LO;

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, REFILL = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [LINE_LOG-1:0] beat;
  logic                victim_way;
  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     dirty_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q   [2][SETS];
  logic [31:0]         data_q  [2][SETS][WORDS];

  logic [LINE_LOG-1:0] offset;
  logic [SETS_LOG-1:0] index;
  logic [TAG_W-1:0]    req_tag;
  logic                req, hit0, hit1, hit, hit_way, victim_sel;
  logic                beat_done, last_beat, addr_unused;

  assign offset      = addr[LINE_LOG+1:2];
  assign index       = addr[TAG_LO-1:LINE_LOG+2];
  assign req_tag     = addr[ADDR_W-1:TAG_LO];
  assign addr_unused = ^addr[1:0];

  assign req       = MemRead | MemWrite;
  assign hit0      = valid_q[0][index] && (tag_q[0][index] == req_tag);
  assign hit1      = valid_q[1][index] && (tag_q[1][index] == req_tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = ~hit0;
  assign beat_done = (state != IDLE) && mem_ready;
  assign last_beat = &beat;

  // Fill empty ways first, then fall back to the LRU choice.
  always_comb begin
    victim_sel = lru_q[index];
    if (!valid_q[0][index])      victim_sel = 1'b0;
    else if (!valid_q[1][index]) victim_sel = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && !hit)
                 state_nxt = (valid_q[victim_sel][index] && dirty_q[victim_sel][index]) ? WB : REFILL;
      WB:      if (beat_done && last_beat) state_nxt = REFILL;
      REFILL:  if (beat_done && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    miss      = 1'b0;
    rd_data   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        miss = req & ~hit;
        if (req && hit) rd_data = data_q[hit_way][index][offset];
      end
      WB: begin
        miss      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[victim_way][index], index, beat, 2'b00};
        mem_wdata = data_q[victim_way][index][beat];
      end
      REFILL: begin
        miss     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, index, beat, 2'b00};
      end
      default: ;
    endcase
  end

  // Control state: line status bits, LRU, beat counter and performance counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat             <= '0;
      victim_way       <= 1'b0;
      valid_q[0]       <= '0;
      valid_q[1]       <= '0;
      dirty_q[0]       <= '0;
      dirty_q[1]       <= '0;
      lru_q            <= '0;
      count_wr_rd_req  <= '0;
      count_cache_miss <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (req && hit) begin
            count_wr_rd_req <= count_wr_rd_req + 32'd1;
            lru_q[index]    <= ~hit_way;
            if (MemWrite) dirty_q[hit_way][index] <= 1'b1;
          end else if (req) begin
            count_cache_miss <= count_cache_miss + 32'd1;
            victim_way       <= victim_sel;
          end
        end
        WB: if (beat_done) beat <= beat + 1'b1;
        REFILL: if (beat_done) begin
          beat <= beat + 1'b1;
          if (last_beat) begin
            valid_q[victim_way][index] <= 1'b1;
            dirty_q[victim_way][index] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && MemWrite)
      data_q[hit_way][index][offset] <= wr_data;
    if (state == REFILL && beat_done) begin
      data_q[victim_way][index][beat] <= mem_rdata;
      if (last_beat) tag_q[victim_way][index] <= req_tag;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl_two_ways.sv
// Bench for dcache_ctrl_two_ways: transaction-level cache and memory model,
// directed scenarios followed by randomized traffic on a conflict-heavy address pool.
module tb_dcache_ctrl_two_ways;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr, wr_data, rd_data, mem_addr, mem_wdata, mem_rdata;
  logic        MemRead, MemWrite, miss, mem_req, mem_we, mem_ready;
  logic [31:0] count_wr_rd_req, count_cache_miss;

  dcache_ctrl_two_ways #(.SETS_LOG(4), .LINE_LOG(2), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .wr_data(wr_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .rd_data(rd_data), .miss(miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .count_wr_rd_req(count_wr_rd_req), .count_cache_miss(count_cache_miss)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {bit we; logic [31:0] addr; logic [31:0] data;} beat_t;
  beat_t       expq[$];
  logic [31:0] bmem[int unsigned];
  logic [31:0] seen_wb[int unsigned];

  bit          m_valid [2][16];
  bit          m_dirty [2][16];
  logic [23:0] m_tag   [2][16];
  logic [31:0] m_data  [2][16][4];
  bit          m_lru   [16];
  int unsigned m_req, m_miss;
  int          gap_cfg = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a + 32'h1000;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 16; s++) m_lru[s] = 1'b0;
    m_req  = 0;
    m_miss = 0;
  endtask

  // Predicts one access: queues the expected memory beats and updates cache/memory state.
  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input int gap, output int exp_cyc, output logic [31:0] exp_rd);
    logic [3:0]  idx;
    logic [23:0] tg;
    logic [31:0] ba, d;
    int          hw, v, nb;
    idx = a[7:4];
    tg  = a[31:8];
    hw  = -1;
    nb  = 0;
    exp_cyc = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tg) hw = w;
    if (hw < 0) begin
      m_miss++;
      if (!m_valid[0][idx])      v = 0;
      else if (!m_valid[1][idx]) v = 1;
      else                       v = int'(m_lru[idx]);
      if (m_valid[v][idx] && m_dirty[v][idx])
        for (int b = 0; b < 4; b++) begin
          ba = {m_tag[v][idx], idx, b[1:0], 2'b00};
          expq.push_back('{1'b1, ba, m_data[v][idx][b]});
          bmem[ba] = m_data[v][idx][b];
          nb++;
        end
      for (int b = 0; b < 4; b++) begin
        ba = {tg, idx, b[1:0], 2'b00};
        d  = mem_word(ba);
        expq.push_back('{1'b0, ba, d});
        m_data[v][idx][b] = d;
        nb++;
      end
      m_valid[v][idx] = 1'b1;
      m_dirty[v][idx] = 1'b0;
      m_tag[v][idx]   = tg;
      hw      = v;
      exp_cyc = 1 + nb * (gap + 1);
    end
    m_req++;
    m_lru[idx] = (hw == 0);
    exp_rd = m_data[hw][idx][a[3:2]];
    if (wr) begin
      m_data[hw][idx][a[3:2]] = wd;
      m_dirty[hw][idx] = 1'b1;
    end
  endtask

  // Backing memory: checks every requested beat against the model and answers after gap_cfg waits.
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (rstn && mem_req) begin
      if (expq.size() == 0) begin
        check("beat_unexpected", mem_addr, 32'hFFFF_FFFF);
      end else begin
        check("beat_we", {31'd0, mem_we}, {31'd0, expq[0].we});
        check("beat_addr", mem_addr, expq[0].addr);
        if (expq[0].we) check("beat_wdata", mem_wdata, expq[0].data);
      end
      if (wait_cnt >= gap_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = (expq.size() != 0) ? expq[0].data : 32'h0;
        if (mem_we) seen_wb[mem_addr] = mem_wdata;
        if (expq.size() != 0) void'(expq.pop_front());
        wait_cnt = 0;
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      wait_cnt  = 0;
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int gap, output int got_cyc, output logic [31:0] got_rd);
    int          exp_cyc;
    logic [31:0] exp_rd;
    model_access(wr, a, wd, gap, exp_cyc, exp_rd);
    gap_cfg = gap;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; addr = a; wr_data = wd;
    got_cyc = 0;
    @(negedge clk);
    while (miss && got_cyc < 300) begin
      got_cyc++;
      @(negedge clk);
    end
    got_rd = rd_data;
    check("miss_cycles", got_cyc, exp_cyc);
    if (rd && !wr) check("rd_data", got_rd, exp_rd);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; addr = $urandom; wr_data = $urandom;
    @(negedge clk);
    check("cnt_req", count_wr_rd_req, m_req);
    check("cnt_miss", count_cache_miss, m_miss);
    check("beats_left", expq.size(), 0);
    check("idle_miss", {31'd0, miss}, 32'd0);
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    check("idle_rd_data", rd_data, 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);
    check("idle_mem_wdata", mem_wdata, 32'd0);
    expq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc, n;
    logic [31:0] rdv, a;
    int          op;
    rstn = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_miss", {31'd0, miss}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_cnt_req", count_wr_rd_req, 32'd0);
    check("rst_cnt_miss", count_cache_miss, 32'd0);

    access(1, 0, 32'h100, 0, 0, cyc, rdv);
    check("cold_cyc", cyc, 5);
    check("cold_rd", rdv, 32'h1100);
    check("cold_cnt_req", count_wr_rd_req, 32'd1);
    check("cold_cnt_miss", count_cache_miss, 32'd1);
    access(1, 0, 32'h104, 0, 0, cyc, rdv);
    check("hit_cyc", cyc, 0);
    check("hit_rd", rdv, 32'h1104);
    check("hit_cnt_req", count_wr_rd_req, 32'd2);

    access(0, 1, 32'h208, 32'hDEADBEEF, 0, cyc, rdv);
    check("wr_miss_cyc", cyc, 5);
    access(1, 0, 32'h100, 0, 0, cyc, rdv);
    check("rehit_rd", rdv, 32'h1100);
    access(1, 0, 32'h300, 0, 0, cyc, rdv);
    check("evict_cyc", cyc, 9);
    check("evict_rd", rdv, 32'h1300);
    check("evict_wb_208", seen_wb.exists(32'h208) ? seen_wb[32'h208] : 32'h0, 32'hDEADBEEF);
    check("evict_wb_200", seen_wb.exists(32'h200) ? seen_wb[32'h200] : 32'h0, 32'h1200);

    access(1, 0, 32'h400, 0, 3, cyc, rdv);
    check("stall_cyc", cyc, 17);
    check("stall_rd", rdv, 32'h1400);

    access(1, 1, 32'h404, 32'h12345678, 0, cyc, rdv);
    check("both_cyc", cyc, 0);
    check("both_cnt_req", count_wr_rd_req, 32'd7);
    access(1, 0, 32'h404, 0, 0, cyc, rdv);
    check("both_store_rd", rdv, 32'h12345678);
    access(1, 0, 32'h504, 0, 0, cyc, rdv);
    check("clean_evict_cyc", cyc, 5);
    access(1, 0, 32'h600, 0, 1, cyc, rdv);
    check("dirty_evict_cyc", cyc, 17);
    check("dirty_wb_404", seen_wb.exists(32'h404) ? seen_wb[32'h404] : 32'h0, 32'h12345678);
    check("dirty_evict_rd", rdv, 32'h1600);

    for (int i = 0; i < 250; i++) begin
      a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, $urandom, $urandom_range(0, 2), cyc, rdv);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    begin
      int          ec;
      logic [31:0] er;
      model_access(1'b0, 32'hA50, 32'h0, 0, ec, er);
      gap_cfg = 0;
      @(posedge clk); #1;
      MemRead = 1'b1; addr = 32'hA50;
      n = 0;
      @(negedge clk);
      while (!(mem_req && mem_addr == 32'hA58) && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("mid_reach_beat2", mem_addr, 32'hA58);
      rstn = 1'b0; MemRead = 1'b0;
      @(negedge clk);
      check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("mid_rst_cnt_req", count_wr_rd_req, 32'd0);
      check("mid_rst_cnt_miss", count_cache_miss, 32'd0);
      rstn = 1'b1;
      model_reset();
      expq.delete();
    end
    access(1, 0, 32'hA50, 0, 0, cyc, rdv);
    check("reread_cyc", cyc, 5);
    check("reread_rd", rdv, 32'h1A50);
    check("reread_cnt_miss", count_cache_miss, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
